// File: rtl/imem_boot_ctrl_if.sv
// Bundle of the byte stream, fetch-address and instruction-memory signals around imem_boot_ctrl.
// master: the environment (receiver, PC, memory); slave: the boot controller.
interface imem_boot_ctrl_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              boot_start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              boot_done;
    logic              boot_err;

    modport master (
        output boot_start, rx_data, rx_valid, cpu_addr,
        input  rx_ready, cpu_stall, mem_addr, mem_wdata, mem_we, boot_done, boot_err
    );

    modport slave (
        input  boot_start, rx_data, rx_valid, cpu_addr,
        output rx_ready, cpu_stall, mem_addr, mem_wdata, mem_we, boot_done, boot_err
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot loader and address-port arbiter for the core's instruction memory.
// Define IMEM_BOOT_CHECKSUM_EN to add a trailing XOR checksum word after the program.
module imem_boot_ctrl #(
    parameter int unsigned ADDR_W = 6
) (
    input logic               clk,
    input logic               rst_n,
    imem_boot_ctrl_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] IDX_ONE = 1;

`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {StHdr, StLoad, StChk, StRun, StErr} state_e;
`else
    typedef enum logic [2:0] {StHdr, StLoad, StRun, StErr} state_e;
`endif

    state_e            state_q;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       buf_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   n_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0]       csum_q;
`endif

    logic              rx_ready;
    logic              fire;
    logic              word_done;
    logic [31:0]       word;
    logic [ADDR_W:0]   idx_nxt;

    always_comb begin
        rx_ready  = (state_q != StRun) && (state_q != StErr);
        fire      = bus.rx_valid && rx_ready;
        word_done = fire && (byte_cnt_q == 2'd3);
        word      = {bus.rx_data, buf_q};
        idx_nxt   = idx_q + IDX_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHdr;
            byte_cnt_q <= 2'd0;
            buf_q      <= 24'd0;
            idx_q      <= '0;
            n_q        <= '0;
            mem_we_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            csum_q     <= 32'd0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (fire) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                unique case (byte_cnt_q)
                    2'd0:    buf_q[7:0]   <= bus.rx_data;
                    2'd1:    buf_q[15:8]  <= bus.rx_data;
                    2'd2:    buf_q[23:16] <= bus.rx_data;
                    default: ;
                endcase
            end
            case (state_q)
                StHdr: begin
                    if (word_done) begin
                        if (word == 32'd0) begin
                            state_q <= StRun;
                        end else if (word > DEPTH) begin
                            state_q <= StErr;
                        end else begin
                            state_q <= StLoad;
                            idx_q   <= '0;
                            n_q     <= word[ADDR_W:0];
`ifdef IMEM_BOOT_CHECKSUM_EN
                            csum_q  <= 32'd0;
`endif
                        end
                    end
                end
                StLoad: begin
                    if (word_done) begin
                        mem_we_q <= 1'b1;
                        waddr_q  <= idx_q[ADDR_W-1:0];
                        wdata_q  <= word;
                        idx_q    <= idx_nxt;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum_q   <= csum_q ^ word;
                        if (idx_nxt == n_q) state_q <= StChk;
`else
                        if (idx_nxt == n_q) state_q <= StRun;
`endif
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                StChk: begin
                    if (word_done) state_q <= (word == csum_q) ? StRun : StErr;
                end
`endif
                StRun, StErr: begin
                    // The byte counter is idle here (rx_ready low), so clearing it cannot race.
                    if (bus.boot_start) begin
                        state_q    <= StHdr;
                        byte_cnt_q <= 2'd0;
                        idx_q      <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        csum_q     <= 32'd0;
`endif
                    end
                end
                default: state_q <= StHdr;
            endcase
        end
    end

    always_comb begin
        bus.rx_ready  = rx_ready;
        bus.mem_we    = mem_we_q;
        bus.mem_wdata = wdata_q;
        if (mem_we_q)                bus.mem_addr = waddr_q;
        else if (state_q == StRun)   bus.mem_addr = bus.cpu_addr;
        else                         bus.mem_addr = waddr_q;
        bus.cpu_stall = !((state_q == StRun) && !mem_we_q);
        bus.boot_done = (state_q == StRun);
        bus.boot_err  = (state_q == StErr);
    end
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected writes are queued by the stimulus and
// popped by a negedge monitor; status outputs are checked directly at directed points.
`timescale 1ns/1ps
module tb_imem_boot_ctrl;
    localparam int unsigned ADDR_W = 6;

    logic clk;
    logic rst_n;
    imem_boot_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [31:0]       prog[64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every mem_we cycle must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
            checks++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h at %0t",
                         bus.mem_addr, bus.mem_wdata, $time);
            end else begin
                logic [ADDR_W-1:0] ea;
                logic [31:0]       ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                if (bus.mem_addr !== ea || bus.mem_wdata !== ed) begin
                    errors++;
                    $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                             bus.mem_addr, bus.mem_wdata, ea, ed);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got %b expected 1", bus.rx_ready);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        if (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    // Header, then words prog[0..n-1] (plus checksum when built in); queues expected writes.
    task automatic load_prog(input logic [31:0] hdr, input bit gap, input bit bad_csum);
        logic [31:0] x = 32'd0;
        send_word(hdr, gap);
        if (hdr != 0 && hdr <= 64) begin
            for (int i = 0; i < int'(hdr); i++) begin
                exp_addr_q.push_back(ADDR_W'(i));
                exp_data_q.push_back(prog[i]);
                x = x ^ prog[i];
                send_word(prog[i], gap);
            end
`ifdef IMEM_BOOT_CHECKSUM_EN
            send_word(bad_csum ? 32'd0 : x, gap);
`endif
        end
    endtask

    task automatic pulse_boot_start();
        bus.boot_start = 1'b1;
        tick();
        bus.boot_start = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.boot_start = 1'b0;
        bus.rx_data    = 8'd0;
        bus.rx_valid   = 1'b0;
        bus.cpu_addr   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;

        chk("reset_rx_ready",  32'(bus.rx_ready),  32'd1);
        chk("reset_cpu_stall", 32'(bus.cpu_stall), 32'd1);
        chk("reset_mem_we",    32'(bus.mem_we),    32'd0);
        chk("reset_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("reset_mem_wdata", bus.mem_wdata,      32'd0);
        chk("reset_boot_done", 32'(bus.boot_done), 32'd0);
        chk("reset_boot_err",  32'(bus.boot_err),  32'd0);

        // Basic back-to-back load of three words.
        prog[0] = 32'h0000_0013;
        prog[1] = 32'h0010_0093;
        prog[2] = 32'hFE00_0EE3;
        load_prog(32'd3, 1'b0, 1'b0);
        chk("basic_boot_done", 32'(bus.boot_done), 32'd1);
`ifndef IMEM_BOOT_CHECKSUM_EN
        chk("basic_last_we",    32'(bus.mem_we),    32'd1);
        chk("basic_stall_hold", 32'(bus.cpu_stall), 32'd1);
`endif
        tick();
        chk("basic_stall_fall", 32'(bus.cpu_stall), 32'd0);
        chk("basic_rx_ready",   32'(bus.rx_ready),  32'd0);
        bus.cpu_addr = 6'd17;
        #1;
        chk("basic_addr_track17", 32'(bus.mem_addr), 32'd17);
        bus.cpu_addr = 6'd42;
        #1;
        chk("basic_addr_track42", 32'(bus.mem_addr), 32'd42);

        // Restart from RUN, then header 0.
        pulse_boot_start();
        chk("restart_boot_done", 32'(bus.boot_done), 32'd0);
        chk("restart_cpu_stall", 32'(bus.cpu_stall), 32'd1);
        chk("restart_rx_ready",  32'(bus.rx_ready),  32'd1);
        load_prog(32'd0, 1'b0, 1'b0);
        chk("hdr0_boot_done", 32'(bus.boot_done), 32'd1);
        chk("hdr0_mem_we",    32'(bus.mem_we),    32'd0);
        tick();
        chk("hdr0_cpu_stall", 32'(bus.cpu_stall), 32'd0);

        // Header 65 overflows the memory.
        pulse_boot_start();
        load_prog(32'd65, 1'b0, 1'b0);
        chk("hdr65_boot_err",  32'(bus.boot_err),  32'd1);
        chk("hdr65_boot_done", 32'(bus.boot_done), 32'd0);
        chk("hdr65_rx_ready",  32'(bus.rx_ready),  32'd0);
        chk("hdr65_cpu_stall", 32'(bus.cpu_stall), 32'd1);

        // Restart from ERR, full 64-word load.
        pulse_boot_start();
        chk("restart_err_clear", 32'(bus.boot_err), 32'd0);
        for (int i = 0; i < 64; i++) prog[i] = (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
        load_prog(32'd64, 1'b0, 1'b0);
        chk("hdr64_boot_done", 32'(bus.boot_done), 32'd1);
        tick();
        chk("hdr64_cpu_stall", 32'(bus.cpu_stall), 32'd0);

        // Gapped stream: rx_valid high every other cycle.
        pulse_boot_start();
        prog[0] = 32'hCAFE_F00D;
        prog[1] = 32'h1357_2468;
        load_prog(32'd2, 1'b1, 1'b0);
        chk("gap_boot_done", 32'(bus.boot_done), 32'd1);

        // Abort after 6 bytes of a 2-word load; word 0 is already written by then.
        pulse_boot_start();
        prog[0] = 32'h1111_2222;
        prog[1] = 32'h3333_4444;
        send_word(32'd2, 1'b0);
        exp_addr_q.push_back(6'd0);
        exp_data_q.push_back(prog[0]);
        send_word(prog[0], 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h44, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort_mem_we",    32'(bus.mem_we),    32'd0);
        chk("abort_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("abort_mem_wdata", bus.mem_wdata,      32'd0);
        chk("abort_boot_done", 32'(bus.boot_done), 32'd0);
        chk("abort_rx_ready",  32'(bus.rx_ready),  32'd1);
        prog[0] = 32'hDEAD_BEEF;
        load_prog(32'd1, 1'b0, 1'b0);
        chk("reload_boot_done", 32'(bus.boot_done), 32'd1);
        tick();
        pulse_boot_start();
        chk("reload_restart_done",  32'(bus.boot_done), 32'd0);
        chk("reload_restart_stall", 32'(bus.cpu_stall), 32'd1);

`ifdef IMEM_BOOT_CHECKSUM_EN
        prog[0] = 32'h1234_5678;
        prog[1] = 32'h0F0F_0F0F;
        load_prog(32'd2, 1'b0, 1'b0);
        chk("csum_good_done", 32'(bus.boot_done), 32'd1);
        chk("csum_good_err",  32'(bus.boot_err),  32'd0);
        pulse_boot_start();
        load_prog(32'd2, 1'b0, 1'b1);
        chk("csum_bad_err",  32'(bus.boot_err),  32'd1);
        chk("csum_bad_done", 32'(bus.boot_done), 32'd0);
`endif

        repeat (3) tick();
        chk("writes_all_seen", 32'(exp_addr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load controller and port arbiter for the single-cycle core's 64-word instruction memory. After reset it holds the core in stall and receives a program as a little-endian byte stream (header word, then N instruction words), writing each assembled word into instruction memory. It then hands the memory address port to the core's fetch path. The block sits between the PC/fetch logic, the serial byte receiver and the writable instruction memory.

## Interface
- ADDR_W, 6, word-address width; depth DEPTH = 2^ADDR_W words
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- boot_start  in  1  single-cycle pulse; restarts loading from RUN or ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  controller accepts a byte this cycle
- cpu_addr  in  ADDR_W  fetch word address from PC
- cpu_stall  out  1  core must hold PC and not retire
- mem_addr  out  ADDR_W  instruction memory address
- mem_wdata  out  32  instruction memory write data
- mem_we  out  1  instruction memory write strobe, one cycle per word
- boot_done  out  1  program loaded, core running
- boot_err  out  1  load failed

## Operation
- States: HDR, LOAD, CHK (only with macro), RUN, ERR. Reset state is HDR.
- A byte transfer occurs on a rising edge with rx_valid && rx_ready. rx_ready = 1 in HDR/LOAD/CHK, 0 in RUN/ERR.
- Word assembly:
  - 2-bit byte counter.
  - Byte k of a word goes to bits [8k+7:8k] (first byte → [7:0]).
  - The word completes on the 4th transfer and the counter wraps to 0.
- HDR: the completed word is N. The following rules apply in order:
  - N == 0: go to RUN, nothing written.
  - N > DEPTH: go to ERR.
  - Otherwise: go to LOAD with word index = 0.
- LOAD:
  - Each completed word is written to memory at word index, which then increments.
  - On completion of word N−1, go to CHK (macro) or RUN.
- Write: mem_we, mem_addr and mem_wdata are registered. The write occurs in the cycle after the 4th byte's acceptance edge. Byte acceptance continues during the write cycle.
- mem_addr mux:
  - mem_we = 1: write address.
  - State RUN: cpu_addr (combinational).
  - Otherwise: holds the last write address.
- cpu_stall = 1 unless state == RUN and mem_we == 0.
- boot_done = 1 exactly in RUN. boot_err = 1 exactly in ERR.
- boot_start in RUN or ERR:
  - Go to HDR.
  - Clear the byte counter, word index and checksum.
  - boot_done and boot_err drop on the next edge.
- boot_start in HDR/LOAD/CHK is ignored.
- Memory contents are not cleared; words beyond N keep their old values.

## Timing
- Reset values:
  - state HDR
  - rx_ready 1
  - cpu_stall 1
  - mem_we 0, mem_addr 0, mem_wdata 0
  - boot_done 0, boot_err 0
  - all counters 0
- rst_n low at any time, including mid-word or mid-load, aborts immediately to the reset state. A partial word is discarded.
- Minimum load time is 4·(N+1) cycles of back-to-back bytes (+4 with checksum). The last mem_we pulse coincides with the first RUN cycle; cpu_stall falls one cycle later.
- rx_valid gaps of any length are tolerated; assembly simply pauses.
- Header word, N=DEPTH=64, loads indices 0..63. The word index is 7 bits internally and does not wrap.

## Configuration
- IMEM_BOOT_CHECKSUM_EN defined:
  - The controller keeps a 32-bit XOR of all N data words. Header excluded; cleared in HDR.
  - After the last data word, the state goes to CHK and one further 4-byte word is received.
  - If that word equals the XOR, go to RUN; otherwise go to ERR.
  - For N == 0 the checksum is skipped.
- IMEM_BOOT_CHECKSUM_EN undefined:
  - There is no CHK state and no checksum logic.
  - LOAD goes directly to RUN.

## Test plan
- Basic load:
  - Stimulus: reset, then stream header 3 followed by 0x00000013, 0x00100093, 0xFE000EE3 (bytes little-endian, back-to-back).
  - Response: mem_we pulses at addresses 0,1,2 with those words. boot_done = 1 one cycle after the last byte. cpu_stall falls one cycle later. mem_addr then tracks cpu_addr.
- Header edge cases:
  - Header 0 → RUN with no writes.
  - Header 65 → ERR: boot_err = 1, rx_ready = 0, cpu_stall = 1.
  - Header 64 with 64 words → all addresses 0..63 written, then RUN.
- Gapped stream:
  - Stimulus: rx_valid toggled every other cycle during a 2-word load.
  - Response: same written words and addresses as the back-to-back case.
- Abort and reload:
  - Stimulus: rst_n pulsed low after 6 bytes of a 2-word load, then a fresh 1-word load of 0xDEADBEEF.
  - Response: single write of 0xDEADBEEF at address 0; boot_done = 1.
  - A subsequent boot_start from RUN returns to HDR with boot_done = 0 and cpu_stall = 1.
- Checksum (macro defined):
  - Stimulus: header 2, words 0x12345678, 0x0F0F0F0F, checksum 0x1D3B5977.
  - Response: RUN.
  - Same load with checksum 0x00000000 → ERR with boot_err = 1.
  - Both words are written in either case.
